dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: MEM_LAT, default 1, synchronous data-memory read latency in cycles (legal 1..4).
REQ-002 Parameter: AW, default 32, address width; DW, default 32, data width.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 cpu_req  in  1  CPU load/store active this cycle; cpu_we  in  1  store (MemWrite).
REQ-006 cpu_addr  in  AW  DataAdr; cpu_wdata  in  DW  WriteData; cpu_rdata  out  DW  ReadData.
REQ-007 cpu_stall  out  1  CPU hold request, drives processor enable low when 1.
REQ-008 dev_req  in  1  secondary master request; dev_we  in  1  write; dev_addr  in  AW; dev_wdata  in  DW.
REQ-009 dev_gnt  out  1  one-cycle pulse, dev access issued; dev_rdata  out  DW; dev_rvalid  out  1  read-data pulse.
REQ-010 mem_addr  out  AW; mem_wdata  out  DW; mem_we  out  1; mem_rdata  in  DW  memory port.

Function
REQ-011 FSM states IDLE, ISSUE, WAIT, RESP; owner register selects CPU or DEV.
REQ-012 IDLE: any request -> ISSUE next cycle; owner latched from arbitration.
REQ-013 Arbitration: single requester wins; both requesting -> winner is master not granted last (round-robin via last_grant bit).
REQ-014 ISSUE: mem_addr/mem_wdata/mem_we driven combinationally from owner's live inputs; requester holds req/addr/we/wdata stable until completion.
REQ-015 ISSUE with write: mem_we=1 for exactly one cycle; access complete; next state IDLE.
REQ-016 ISSUE with read: mem_we=0; next state WAIT if MEM_LAT>1 else RESP; WAIT lasts MEM_LAT-1 cycles (counter).
REQ-017 RESP: mem_rdata valid; next state IDLE; CPU read latency = MEM_LAT+1 cycles after request cycle.
REQ-018 dev_gnt=1 only in the ISSUE cycle of a DEV-owned access.
REQ-019 dev_rvalid=1 and dev_rdata=mem_rdata only in RESP of a DEV read; dev_rdata otherwise holds last value.
REQ-020 cpu_stall = cpu_req AND NOT cpu_done; cpu_done = CPU-owned ISSUE-write or CPU-owned RESP cycle.
REQ-021 cpu_rdata = mem_rdata in CPU RESP cycle (combinational), also latched; otherwise holds latched value.
REQ-022 mem_we=0 in every state except ISSUE-write; mem_addr/mem_wdata hold last issued value outside ISSUE.
REQ-023 Requests arriving in ISSUE/WAIT/RESP are not accepted; evaluated in next IDLE; no request dropped while held.
REQ-024 Requester deasserting req before completion: access still completes; response discarded only if owner's req low in RESP.
REQ-025 Minimum spacing: consecutive accesses separated by at least one IDLE cycle.

Reset
REQ-026 reset=0: immediately state=IDLE, last_grant=DEV (CPU wins first tie), counter=0.
REQ-027 reset=0: mem_we=0, mem_addr=0, mem_wdata=0, dev_gnt=0, dev_rvalid=0, dev_rdata=0, cpu_rdata=0.
REQ-028 cpu_stall remains combinational from cpu_req during reset (IDLE, no completion -> stall follows cpu_req).
REQ-029 Reset mid-access: in-flight access abandoned, no rvalid/gnt pulse, no write after release.

Configuration
REQ-030 Macro DMEM_ARB_PERF_EN defined: adds output contention_cnt (16 bits), incremented each cycle cpu_stall=1, saturates at 0xFFFF, cleared by reset.
REQ-031 Macro undefined: contention_cnt port and logic absent; all other behaviour identical.

Verification
REQ-032 CPU read only, MEM_LAT=1, addr 0x40, mem holds 0x1234 -> cpu_stall high 2 cycles, cpu_rdata=0x1234 in RESP cycle, stall low same cycle.
REQ-033 CPU write 0xDEAD to 0x80 -> mem_we single pulse in ISSUE with mem_addr=0x80, mem_wdata=0xDEAD; stall low that cycle.
REQ-034 CPU and DEV request same cycle after reset, held -> CPU served first, DEV next (dev_gnt after CPU done); repeat tie -> order alternates.
REQ-035 DEV read 0x10, MEM_LAT=3 -> dev_gnt at ISSUE, dev_rvalid one pulse 3 cycles later with correct data.
REQ-036 reset=0 during WAIT of DEV read -> no dev_rvalid, outputs at reset values, next CPU request served normally.
REQ-037 DMEM_ARB_PERF_EN defined, 5 stalled CPU cycles -> contention_cnt=5; undefined -> port absent, build clean.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: shares one synchronous-read memory port between the CPU and a secondary master.
// Optional build macro DMEM_ARB_PERF_EN adds a saturating CPU stall counter (contention_cnt).
module dmem_arbiter #(
    parameter int unsigned MEM_LAT = 1,
    parameter int unsigned AW      = 32,
    parameter int unsigned DW      = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          dev_req,
    input  logic          dev_we,
    input  logic [AW-1:0] dev_addr,
    input  logic [DW-1:0] dev_wdata,
    output logic          dev_gnt,
    output logic [DW-1:0] dev_rdata,
    output logic          dev_rvalid,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_we,
    input  logic [DW-1:0] mem_rdata
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [15:0]   contention_cnt
`endif
);

    localparam int unsigned    CW        = 2;
    localparam logic [CW-1:0]  WAIT_INIT = (MEM_LAT > 1) ? CW'(MEM_LAT - 2) : '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_e;

    typedef enum logic {
        OWN_CPU,
        OWN_DEV
    } owner_e;

    state_e        state_q, state_d;
    owner_e        owner_q, owner_d;
    owner_e        last_grant_q, last_grant_d;
    owner_e        win_c;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] dev_rdata_q, dev_rdata_d;
    logic          dev_gnt_q, dev_gnt_d;
    logic          dev_rvalid_q, dev_rvalid_d;

    logic          own_we_c;
    logic [AW-1:0] own_addr_c;
    logic [DW-1:0] own_wdata_c;
    logic          issue_c;
    logic          resp_c;
    logic          cpu_resp_c;
    logic          dev_resp_c;
    logic          cpu_done_c;

    // Live request fields of the current owner; held stable by the requester until completion.
    assign own_we_c    = (owner_q == OWN_CPU) ? cpu_we    : dev_we;
    assign own_addr_c  = (owner_q == OWN_CPU) ? cpu_addr  : dev_addr;
    assign own_wdata_c = (owner_q == OWN_CPU) ? cpu_wdata : dev_wdata;

    assign issue_c    = (state_q == ST_ISSUE);
    assign resp_c     = (state_q == ST_RESP);
    assign cpu_resp_c = resp_c && (owner_q == OWN_CPU) && cpu_req;
    assign dev_resp_c = resp_c && (owner_q == OWN_DEV) && dev_req;

    // Round-robin on a tie: the master not granted last wins.
    assign win_c = (cpu_req && dev_req) ? ((last_grant_q == OWN_DEV) ? OWN_CPU : OWN_DEV)
                                        : (cpu_req ? OWN_CPU : OWN_DEV);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            owner_q      <= OWN_CPU;
            last_grant_q <= OWN_DEV;
            cnt_q        <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_rdata_q  <= '0;
            dev_rdata_q  <= '0;
            dev_gnt_q    <= 1'b0;
            dev_rvalid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            cnt_q        <= cnt_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
            dev_rdata_q  <= dev_rdata_d;
            dev_gnt_q    <= dev_gnt_d;
            dev_rvalid_q <= dev_rvalid_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        cnt_d        = cnt_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        cpu_rdata_d  = cpu_rdata_q;
        dev_rdata_d  = dev_rdata_q;

        unique case (state_q)
            ST_IDLE: begin
                if (cpu_req || dev_req) begin
                    state_d      = ST_ISSUE;
                    owner_d      = win_c;
                    last_grant_d = win_c;
                end
            end
            ST_ISSUE: begin
                mem_addr_d  = own_addr_c;
                mem_wdata_d = own_wdata_c;
                if (own_we_c) begin
                    state_d = ST_IDLE;
                end else if (MEM_LAT > 1) begin
                    state_d = ST_WAIT;
                    cnt_d   = WAIT_INIT;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
                if (cpu_resp_c) begin
                    cpu_rdata_d = mem_rdata;
                end
                if (dev_resp_c) begin
                    dev_rdata_d = mem_rdata;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Pulses are decoded one cycle ahead so they come straight from flops.
        dev_gnt_d    = (state_d == ST_ISSUE) && (owner_d == OWN_DEV);
        dev_rvalid_d = (state_d == ST_RESP) && (owner_d == OWN_DEV);
    end

    assign cpu_done_c = (owner_q == OWN_CPU) && ((issue_c && cpu_we) || resp_c);
    assign cpu_stall  = cpu_req && !cpu_done_c;

    assign mem_we     = issue_c && own_we_c;
    assign mem_addr   = issue_c ? own_addr_c  : mem_addr_q;
    assign mem_wdata  = issue_c ? own_wdata_c : mem_wdata_q;

    // Read data is forwarded in the response cycle and held afterwards.
    assign cpu_rdata  = cpu_resp_c ? mem_rdata : cpu_rdata_q;
    assign dev_rdata  = dev_resp_c ? mem_rdata : dev_rdata_q;
    assign dev_gnt    = dev_gnt_q;
    assign dev_rvalid = dev_rvalid_q && dev_req;

`ifdef DMEM_ARB_PERF_EN
    logic [15:0] contention_cnt_q;

    // Saturating count of cycles the CPU is held.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            contention_cnt_q <= '0;
        end else if (cpu_stall && (contention_cnt_q != 16'hFFFF)) begin
            contention_cnt_q <= contention_cnt_q + 16'd1;
        end
    end

    assign contention_cnt = contention_cnt_q;
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: instance A has MEM_LAT=1, instance B has MEM_LAT=3.
module tb_dmem_arbiter;
    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] cpu_q[$];
    logic [DW-1:0] dev_q[$];
    int            order_q[$];

    logic a_reset, a_cpu_req, a_cpu_we, a_dev_req, a_dev_we, a_cpu_stall, a_dev_gnt, a_dev_rvalid, a_mem_we;
    logic [AW-1:0] a_cpu_addr, a_dev_addr, a_mem_addr;
    logic [DW-1:0] a_cpu_wdata, a_dev_wdata, a_cpu_rdata, a_dev_rdata, a_mem_wdata, a_mem_rdata;
    logic b_reset, b_cpu_req, b_cpu_we, b_dev_req, b_dev_we, b_cpu_stall, b_dev_gnt, b_dev_rvalid, b_mem_we;
    logic [AW-1:0] b_cpu_addr, b_dev_addr, b_mem_addr;
    logic [DW-1:0] b_cpu_wdata, b_dev_wdata, b_cpu_rdata, b_dev_rdata, b_mem_wdata, b_mem_rdata;
`ifdef DMEM_ARB_PERF_EN
    logic [15:0] a_cnt, b_cnt;
`endif

    dmem_arbiter #(.MEM_LAT(1), .AW(AW), .DW(DW)) u_dut_a (
        .clk(clk), .reset(a_reset),
        .cpu_req(a_cpu_req), .cpu_we(a_cpu_we), .cpu_addr(a_cpu_addr), .cpu_wdata(a_cpu_wdata),
        .cpu_rdata(a_cpu_rdata), .cpu_stall(a_cpu_stall),
        .dev_req(a_dev_req), .dev_we(a_dev_we), .dev_addr(a_dev_addr), .dev_wdata(a_dev_wdata),
        .dev_gnt(a_dev_gnt), .dev_rdata(a_dev_rdata), .dev_rvalid(a_dev_rvalid),
        .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata), .mem_we(a_mem_we), .mem_rdata(a_mem_rdata)
`ifdef DMEM_ARB_PERF_EN
        , .contention_cnt(a_cnt)
`endif
    );

    dmem_arbiter #(.MEM_LAT(3), .AW(AW), .DW(DW)) u_dut_b (
        .clk(clk), .reset(b_reset),
        .cpu_req(b_cpu_req), .cpu_we(b_cpu_we), .cpu_addr(b_cpu_addr), .cpu_wdata(b_cpu_wdata),
        .cpu_rdata(b_cpu_rdata), .cpu_stall(b_cpu_stall),
        .dev_req(b_dev_req), .dev_we(b_dev_we), .dev_addr(b_dev_addr), .dev_wdata(b_dev_wdata),
        .dev_gnt(b_dev_gnt), .dev_rdata(b_dev_rdata), .dev_rvalid(b_dev_rvalid),
        .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata), .mem_we(b_mem_we), .mem_rdata(b_mem_rdata)
`ifdef DMEM_ARB_PERF_EN
        , .contention_cnt(b_cnt)
`endif
    );

    // Memory models: unwritten words return a fixed pattern, 0x40 holds 0x1234.
    function automatic logic [DW-1:0] mem_init(input logic [AW-1:0] a);
        return (a == 32'h40) ? 32'h1234 : {16'hC0DE, a[15:0]};
    endfunction

    bit   [DW-1:0] a_mem_w [256];
    bit   [255:0]  a_mem_v;
    logic [DW-1:0] a_pipe;
    bit   [DW-1:0] b_mem_w [256];
    bit   [255:0]  b_mem_v;
    logic [DW-1:0] b_pipe [3];

    always @(posedge clk) begin
        if (a_mem_we) begin
            a_mem_w[a_mem_addr[9:2]] <= a_mem_wdata;
            a_mem_v[a_mem_addr[9:2]] <= 1'b1;
        end
        a_pipe <= a_mem_v[a_mem_addr[9:2]] ? a_mem_w[a_mem_addr[9:2]] : mem_init(a_mem_addr);
        if (b_mem_we) begin
            b_mem_w[b_mem_addr[9:2]] <= b_mem_wdata;
            b_mem_v[b_mem_addr[9:2]] <= 1'b1;
        end
        b_pipe[0] <= b_mem_v[b_mem_addr[9:2]] ? b_mem_w[b_mem_addr[9:2]] : mem_init(b_mem_addr);
        b_pipe[1] <= b_pipe[0];
        b_pipe[2] <= b_pipe[1];
    end
    assign a_mem_rdata = a_pipe;
    assign b_mem_rdata = b_pipe[2];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One CPU access on instance A (inst_b=0) or B (inst_b=1); returns one cycle after completion.
    task automatic cpu_access(input bit inst_b, input logic we, input logic [AW-1:0] addr,
                              input logic [DW-1:0] wdata, input logic [DW-1:0] rexp);
        int stalls = 0;
        bit done = 0;
        int lat = inst_b ? 3 : 1;
        if (inst_b) begin
            b_cpu_req = 1'b1; b_cpu_we = we; b_cpu_addr = addr; b_cpu_wdata = wdata;
        end else begin
            a_cpu_req = 1'b1; a_cpu_we = we; a_cpu_addr = addr; a_cpu_wdata = wdata;
        end
        if (!we) cpu_q.push_back(rexp);
        for (int i = 0; i < 20 && !done; i++) begin
            @(negedge clk);
            if (inst_b ? b_cpu_stall : a_cpu_stall) begin
                stalls++;
            end else begin
                done = 1;
                if (we) begin
                    check("wr_mem_we",    64'(inst_b ? b_mem_we : a_mem_we), 64'(1));
                    check("wr_mem_addr",  64'(inst_b ? b_mem_addr : a_mem_addr), 64'(addr));
                    check("wr_mem_wdata", 64'(inst_b ? b_mem_wdata : a_mem_wdata), 64'(wdata));
                end else begin
                    check("rd_cpu_rdata", 64'(inst_b ? b_cpu_rdata : a_cpu_rdata), 64'(cpu_q.pop_front()));
                end
            end
            @(posedge clk); #1;
        end
        check("cpu_done_in_time", 64'(done), 64'(1));
        check("cpu_stall_cycles", 64'(stalls), we ? 64'(1) : 64'(lat + 1));
        if (inst_b) begin
            b_cpu_req = 1'b0; b_cpu_we = 1'b0;
        end else begin
            a_cpu_req = 1'b0; a_cpu_we = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int gnt_cyc, rv_cyc, gnt_n, rv_n, bad_n;
        bit gnt_seen;
        logic [1:0] ev;

        a_reset = 1'b0; a_cpu_req = 1'b0; a_cpu_we = 1'b0; a_cpu_addr = '0; a_cpu_wdata = '0;
        a_dev_req = 1'b0; a_dev_we = 1'b0; a_dev_addr = '0; a_dev_wdata = '0;
        b_reset = 1'b0; b_cpu_req = 1'b0; b_cpu_we = 1'b0; b_cpu_addr = '0; b_cpu_wdata = '0;
        b_dev_req = 1'b0; b_dev_we = 1'b0; b_dev_addr = '0; b_dev_wdata = '0;

        // Reset values, and stall following cpu_req while reset is held.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_we",     64'(a_mem_we), 64'(0));
        check("rst_mem_addr",   64'(a_mem_addr), 64'(0));
        check("rst_mem_wdata",  64'(a_mem_wdata), 64'(0));
        check("rst_dev_gnt",    64'(a_dev_gnt), 64'(0));
        check("rst_dev_rvalid", 64'(a_dev_rvalid), 64'(0));
        check("rst_dev_rdata",  64'(a_dev_rdata), 64'(0));
        check("rst_cpu_rdata",  64'(a_cpu_rdata), 64'(0));
        a_cpu_req = 1'b1;
        #1 check("rst_stall_follows_req", 64'(a_cpu_stall), 64'(1));
        a_cpu_req = 1'b0;
        #1 check("rst_stall_low", 64'(a_cpu_stall), 64'(0));
        @(posedge clk); #1;
        a_reset = 1'b1; b_reset = 1'b1;

        // CPU read, write, read-back on MEM_LAT=1.
        cpu_access(1'b0, 1'b0, 32'h40, '0, 32'h1234);
        @(negedge clk);
        check("rd_hold_cpu_rdata", 64'(a_cpu_rdata), 64'(32'h1234));
        @(posedge clk); #1;
        cpu_access(1'b0, 1'b1, 32'h80, 32'hDEAD, '0);
        @(negedge clk);
        check("wr_after_mem_we",    64'(a_mem_we), 64'(0));
        check("wr_after_mem_addr",  64'(a_mem_addr), 64'(32'h80));
        check("wr_after_mem_wdata", 64'(a_mem_wdata), 64'(32'hDEAD));
        @(posedge clk); #1;
        cpu_access(1'b0, 1'b0, 32'h80, '0, 32'hDEAD);
`ifdef DMEM_ARB_PERF_EN
        @(negedge clk);
        check("perf_contention_cnt", 64'(a_cnt), 64'(5));
        @(posedge clk); #1;
`endif

        // Tie after reset, both held: CPU, DEV, CPU, DEV.
        a_reset = 1'b0;
        #1 check("rst2_cpu_rdata", 64'(a_cpu_rdata), 64'(0));
        @(posedge clk); #1;
        a_reset = 1'b1;
        order_q = '{1, 2, 1, 2};
        cpu_q.push_back(32'h1234);    cpu_q.push_back(32'h1234);
        dev_q.push_back(32'hC0DE0020); dev_q.push_back(32'hC0DE0020);
        a_cpu_req = 1'b1; a_cpu_we = 1'b0; a_cpu_addr = 32'h40;
        a_dev_req = 1'b1; a_dev_we = 1'b0; a_dev_addr = 32'h20;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            ev = {a_dev_gnt, a_cpu_req & ~a_cpu_stall};
            if (ev != 2'b00) begin
                if (order_q.size() == 0) check("tie_extra_event", 64'(ev), 64'(0));
                else check("tie_order", 64'(ev), 64'(order_q.pop_front()));
            end
            if (ev[0]) begin
                if (cpu_q.size() == 0) check("tie_extra_cpu", 64'(1), 64'(0));
                else check("tie_cpu_rdata", 64'(a_cpu_rdata), 64'(cpu_q.pop_front()));
            end
            if (a_dev_rvalid) begin
                if (dev_q.size() == 0) check("tie_extra_rvalid", 64'(1), 64'(0));
                else check("tie_dev_rdata", 64'(a_dev_rdata), 64'(dev_q.pop_front()));
            end
            @(posedge clk); #1;
        end
        a_cpu_req = 1'b0; a_dev_req = 1'b0;
        check("tie_all_events_seen", 64'(order_q.size() + cpu_q.size() + dev_q.size()), 64'(0));
        @(negedge clk);
        check("tie_dev_rdata_hold", 64'(a_dev_rdata), 64'(32'hC0DE0020));
        check("tie_idle_gnt", 64'(a_dev_gnt), 64'(0));
        @(posedge clk); #1;

        // DEV read on MEM_LAT=3: grant in ISSUE, rvalid three cycles later.
        gnt_cyc = -1; rv_cyc = -1; gnt_n = 0; rv_n = 0;
        dev_q.push_back(32'hC0DE0010);
        b_dev_req = 1'b1; b_dev_we = 1'b0; b_dev_addr = 32'h10;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (b_dev_gnt) begin gnt_n++; gnt_cyc = c; end
            if (b_dev_rvalid) begin
                rv_n++; rv_cyc = c;
                if (dev_q.size() == 0) check("dev_extra_rvalid", 64'(1), 64'(0));
                else check("dev_rdata", 64'(b_dev_rdata), 64'(dev_q.pop_front()));
            end
            @(posedge clk); #1;
            if (rv_n > 0) b_dev_req = 1'b0;
        end
        b_dev_req = 1'b0;
        check("dev_gnt_cycle",   64'(gnt_cyc), 64'(1));
        check("dev_rvalid_cycle", 64'(rv_cyc), 64'(4));
        check("dev_gnt_count",   64'(gnt_n), 64'(1));
        check("dev_rvalid_count", 64'(rv_n), 64'(1));

        // Reset during WAIT of a DEV read.
        gnt_seen = 0;
        b_dev_req = 1'b1; b_dev_addr = 32'h10;
        for (int c = 0; c < 6 && !gnt_seen; c++) begin
            @(negedge clk);
            if (b_dev_gnt) gnt_seen = 1;
            @(posedge clk); #1;
        end
        check("rstw_gnt_seen", 64'(gnt_seen), 64'(1));
        b_reset = 1'b0; b_dev_req = 1'b0;
        #1;
        check("rstw_dev_rvalid", 64'(b_dev_rvalid), 64'(0));
        check("rstw_dev_gnt",    64'(b_dev_gnt), 64'(0));
        check("rstw_dev_rdata",  64'(b_dev_rdata), 64'(0));
        check("rstw_mem_we",     64'(b_mem_we), 64'(0));
        check("rstw_mem_addr",   64'(b_mem_addr), 64'(0));
        check("rstw_mem_wdata",  64'(b_mem_wdata), 64'(0));
        repeat (2) @(posedge clk);
        #1 b_reset = 1'b1;
        bad_n = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (b_dev_rvalid || b_dev_gnt || b_mem_we) bad_n++;
            @(posedge clk); #1;
        end
        check("rstw_quiet_after", 64'(bad_n), 64'(0));
        cpu_access(1'b1, 1'b0, 32'h40, '0, 32'h1234);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
